memory_writer_cu: RTL

Control unit plus address generator that drains convolution results from the output datapath and writes them back to memory. It is the write-back counterpart of the memory reader control unit: that unit loads filters and image words into local buffers, and this unit stores the resulting feature-map words into per-filter output regions. It accepts a `start` pulse after computation is launched, handshakes each result word with the datapath, issues one memory write per word, and pulses `done` when the whole output map has been written.

---
 rtl/memory_writer_cu.sv | 134 +++++++++++++
 1 files changed

// File: rtl/memory_writer_cu.sv
// Write-back control unit: drains result words from the datapath and stores them filter-major.
// Optional `MEM_WR_ACK_EN holds each write until the memory acknowledges it.
module memory_writer_cu #(
    parameter int unsigned IMG_SIZE    = 16,
    parameter int unsigned NUM_FILTERS = 4,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned OUT_BASE    = 32'h0000_0100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              res_ready,
    input  logic              mem_ack,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [15:0]       words_written
);

    localparam int unsigned GROUPS = IMG_SIZE * IMG_SIZE / 4;
    localparam int unsigned FW     = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int unsigned GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [FW-1:0] LAST_F = FW'(NUM_FILTERS - 1);
    localparam logic [GW-1:0] LAST_G = GW'(GROUPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_WAIT_RES,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [FW-1:0]     cntr_filter_q, cntr_filter_d;
    logic [GW-1:0]     cntr_group_q, cntr_group_d;
    logic [15:0]       words_written_q, words_written_d;
    logic [ADDR_W-1:0] mem_adr_q, mem_adr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              wr_done;

`ifdef MEM_WR_ACK_EN
    assign wr_done = (state_q == S_WRITE) && mem_ack;
`else
    logic unused_mem_ack;
    assign unused_mem_ack = mem_ack;
    assign wr_done        = (state_q == S_WRITE);
`endif

    always_comb begin
        state_d         = state_q;
        cntr_filter_d   = cntr_filter_q;
        cntr_group_d    = cntr_group_q;
        words_written_d = words_written_q;
        mem_adr_d       = mem_adr_q;
        mem_wdata_d     = mem_wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_INIT;
            end
            S_INIT: begin
                cntr_filter_d   = '0;
                cntr_group_d    = '0;
                words_written_d = '0;
                state_d         = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                // Address is latched with the data so both stay stable through WRITE.
                if (res_valid) begin
                    mem_wdata_d = res_data;
                    mem_adr_d   = ADDR_W'(OUT_BASE + 32'(cntr_filter_q) * GROUPS + 32'(cntr_group_q));
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                if (wr_done) begin
                    words_written_d = words_written_q + 16'd1;
                    state_d         = S_WAIT_RES;
                    if (cntr_filter_q == LAST_F) begin
                        cntr_filter_d = '0;
                        cntr_group_d  = cntr_group_q + GW'(1);
                        if (cntr_group_q == LAST_G) state_d = S_DONE;
                    end else begin
                        cntr_filter_d = cntr_filter_q + FW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntr_filter_q   <= '0;
            cntr_group_q    <= '0;
            words_written_q <= '0;
            mem_adr_q       <= '0;
            mem_wdata_q     <= '0;
        end else begin
            cntr_filter_q   <= cntr_filter_d;
            cntr_group_q    <= cntr_group_d;
            words_written_q <= words_written_d;
            mem_adr_q       <= mem_adr_d;
            mem_wdata_q     <= mem_wdata_d;
        end
    end

    assign res_ready     = (state_q == S_WAIT_RES);
    assign mem_wr_en     = (state_q == S_WRITE);
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign mem_adr       = mem_adr_q;
    assign mem_wdata     = mem_wdata_q;
    assign words_written = words_written_q;

endmodule
